// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Throttles on full/almostfull and counts missing write acks and overflow pulses.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]  owner,
    output logic                        busy,
    output logic [7:0]                  nack_cnt,
    output logic [7:0]                  ovf_cnt
);

    localparam int unsigned OWN_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [OWN_W-1:0]   rr_ptr;
    logic [OWN_W-1:0]   rr_ptr_nxt;
    logic [OWN_W-1:0]   owner_nxt;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   burst_cnt_nxt;
    logic               wr_en_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               wr_en_prev;
    logic               found;
    int unsigned        idx;

    logic               space_c;
    logic               accept_c;
    logic [DATA_W-1:0]  sel_data_c;

    // A registered write may still be in flight, so almostfull counts as full while wr_en is high.
    assign space_c    = !fifo_full && !(fifo_almostfull && fifo_wr_en);
    assign accept_c   = (state_q == BURST) && req[owner] && space_c;
    assign sel_data_c = req_data[32'(owner) * DATA_W +: DATA_W];

    // Combinational grant to the current owner only.
    always_comb begin
        req_gnt = '0;
        if ((state_q == BURST) && space_c) begin
            req_gnt[owner] = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state_q;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        wr_en_nxt     = 1'b0;
        data_nxt      = fifo_data_in;
        found         = 1'b0;
        idx           = 0;
        unique case (state_q)
            IDLE: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    idx = 32'(rr_ptr) + k;
                    if (idx >= NUM_REQ) begin
                        idx = idx - NUM_REQ;
                    end
                    if (!found && req[OWN_W'(idx)]) begin
                        found     = 1'b1;
                        owner_nxt = OWN_W'(idx);
                    end
                end
                if (found) begin
                    state_nxt     = BURST;
                    burst_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (accept_c) begin
                    wr_en_nxt     = 1'b1;
                    data_nxt      = sel_data_c;
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
                if ((accept_c && (burst_cnt == LAST_BEAT)) || !req[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (32'(owner) == NUM_REQ - 1) ? '0 : owner + OWN_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            burst_cnt    <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            busy         <= 1'b0;
            wr_en_prev   <= 1'b0;
            nack_cnt     <= '0;
            ovf_cnt      <= '0;
        end else begin
            state_q      <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            owner        <= owner_nxt;
            burst_cnt    <= burst_cnt_nxt;
            fifo_wr_en   <= wr_en_nxt;
            fifo_data_in <= data_nxt;
            busy         <= (state_nxt == BURST);
            wr_en_prev   <= fifo_wr_en;
            // The ack for a write issued in cycle K is due in cycle K+1.
            if (wr_en_prev && !fifo_wr_ack && (nack_cnt != CNT_MAX)) begin
                nack_cnt <= nack_cnt + CNT_W'(1);
            end
            if (fifo_overflow && (ovf_cnt != CNT_MAX)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural 8-deep FIFO, per-producer word streams,
// and a scoreboard of accepted words compared against the registered FIFO write port.
module tb_fifo_wr_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned DEPTH     = 8;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_gnt;
    logic [DATA_W-1:0]           fifo_data_in;
    logic                        fifo_wr_en;
    logic                        fifo_full;
    logic                        fifo_almostfull;
    logic                        fifo_wr_ack;
    logic                        fifo_overflow;
    logic [1:0]                  owner;
    logic                        busy;
    logic [7:0]                  nack_cnt;
    logic [7:0]                  ovf_cnt;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .req_gnt        (req_gnt),
        .fifo_data_in   (fifo_data_in),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_full      (fifo_full),
        .fifo_almostfull(fifo_almostfull),
        .fifo_wr_ack    (fifo_wr_ack),
        .fifo_overflow  (fifo_overflow),
        .owner          (owner),
        .busy           (busy),
        .nack_cnt       (nack_cnt),
        .ovf_cnt        (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: writes when not full, optional read, ack suppression for nack tests.
    logic fifo_clr = 1'b1;
    logic rd_en    = 1'b1;
    logic ack_kill = 1'b0;
    int   fcnt     = 0;
    int   n_writes = 0;

    assign fifo_full       = (fcnt == DEPTH);
    assign fifo_almostfull = (fcnt == DEPTH - 1);

    always @(posedge clk) begin
        if (fifo_clr) begin
            fcnt          <= 0;
            fifo_wr_ack   <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            fcnt          <= fcnt + ((fifo_wr_en && fcnt < DEPTH) ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
            fifo_wr_ack   <= fifo_wr_en && (fcnt < DEPTH) && !ack_kill;
            fifo_overflow <= fifo_wr_en && (fcnt == DEPTH);
            if (fifo_wr_en && fcnt < DEPTH) n_writes <= n_writes + 1;
        end
    end

    int                n_assert = 0;
    int                n_fail   = 0;
    int                n_wr     = 0;
    logic [DATA_W-1:0] sb[$];
    int                glog[$];
    bit                log_en   = 1'b0;
    logic [DATA_W-1:0] base[NUM_REQ];
    int                remain[NUM_REQ];
    int                sent[NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (remain[i] > 0);
            req_data[i*DATA_W +: DATA_W] = base[i] + DATA_W'(sent[i]);
        end
    endtask

    // One clock: record accepts before the edge, check the write port after it, advance producers.
    task automatic tick();
        logic [NUM_REQ-1:0] taken;
        int                 who;
        logic [DATA_W-1:0]  exp_d;
        @(negedge clk);
        taken = rst ? '0 : (req & req_gnt);
        who   = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (taken[i]) begin
                sb.push_back(req_data[i*DATA_W +: DATA_W]);
                who = i;
            end
        end
        if (log_en) glog.push_back(who);
        @(posedge clk);
        #1;
        chk("wr_en", 32'(fifo_wr_en), 32'(taken != '0));
        if (fifo_wr_en) begin
            n_wr++;
            if (sb.size() > 0) begin
                exp_d = sb.pop_front();
                chk("data_in", 32'(fifo_data_in), 32'(exp_d));
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (taken[i]) begin
                sent[i]++;
                remain[i]--;
            end
        end
        drive();
    endtask

    initial begin
        int order[5];
        int w0;
        order = '{3, 0, 1, 2, 3};
        for (int i = 0; i < NUM_REQ; i++) begin
            base[i]   = DATA_W'(16'h1000 * (i + 1));
            remain[i] = 1;
            sent[i]   = 0;
        end
        rst = 1'b1;
        drive();

        // Reset with all requests high.
        tick();
        tick();
        chk("rst_gnt", 32'(req_gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_nack", 32'(nack_cnt), 32'h0);
        chk("rst_ovf", 32'(ovf_cnt), 32'h0);

        // Single producer 2, three words A1..A3.
        rst      = 1'b0;
        fifo_clr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) remain[i] = 0;
        base[2]   = 16'h00A1;
        sent[2]   = 0;
        remain[2] = 3;
        drive();
        n_wr = 0;
        tick();
        chk("t2_busy", 32'(busy), 32'h1);
        chk("t2_owner", 32'(owner), 32'h2);
        tick();
        tick();
        tick();
        tick();
        chk("t2_idle", 32'(busy), 32'h0);
        chk("t2_wr_cycles", 32'(n_wr), 32'd3);

        // All four streaming: rr_ptr=3 so order 3,0,1,2,3 with one bubble per burst.
        for (int i = 0; i < NUM_REQ; i++) begin
            remain[i] = 1000;
            sent[i]   = 0;
            base[i]   = DATA_W'(16'h1000 * (i + 1));
        end
        drive();
        log_en = 1'b1;
        for (int t = 0; t < 45; t++) tick();
        log_en = 1'b0;
        for (int b = 0; b < 5; b++) begin
            chk("t3_bubble", 32'(glog[b*9]), 32'hFFFF_FFFF);
            for (int j = 1; j <= 8; j++) chk("t3_order", 32'(glog[b*9+j]), 32'(order[b]));
        end
        for (int i = 0; i < NUM_REQ; i++) remain[i] = 0;
        drive();
        tick();
        tick();

        // Unread 8-deep FIFO: exactly 8 writes, then throttled with no overflow.
        fifo_clr = 1'b1;
        tick();
        fifo_clr  = 1'b0;
        rd_en     = 1'b0;
        n_wr      = 0;
        base[0]   = 16'h5000;
        sent[0]   = 0;
        remain[0] = 1000;
        drive();
        for (int t = 0; t < 30; t++) tick();
        chk("t4_writes", 32'(n_wr), 32'd8);
        chk("t4_gnt", 32'(req_gnt), 32'h0);
        chk("t4_busy", 32'(busy), 32'h1);
        chk("t4_ovf", 32'(ovf_cnt), 32'h0);
        chk("t4_nack", 32'(nack_cnt), 32'h0);

        // Missing acks: two, then saturation.
        remain[0] = 0;
        rd_en     = 1'b1;
        drive();
        for (int t = 0; t < 12; t++) tick();
        ack_kill  = 1'b1;
        base[1]   = 16'h6000;
        sent[1]   = 0;
        remain[1] = 2;
        drive();
        for (int t = 0; t < 6; t++) tick();
        chk("t5_nack2", 32'(nack_cnt), 32'd2);
        remain[1] = 300;
        drive();
        for (int t = 0; t < 600 && remain[1] > 0; t++) tick();
        chk("t5_bound", 32'(remain[1]), 32'h0);
        for (int t = 0; t < 4; t++) tick();
        chk("t5_nack_sat", 32'(nack_cnt), 32'd255);
        chk("t5_ovf", 32'(ovf_cnt), 32'h0);

        // Reset mid-burst after four accepts; the in-flight fourth word still lands.
        ack_kill = 1'b0;
        tick();
        tick();
        w0        = n_writes;
        base[2]   = 16'h7000;
        sent[2]   = 0;
        remain[2] = 1000;
        drive();
        for (int t = 0; t < 5; t++) tick();
        chk("t6_cnt4", 32'(sent[2]), 32'd4);
        rst       = 1'b1;
        remain[2] = 0;
        drive();
        tick();
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_inflight", 32'(n_writes - w0), 32'd4);
        chk("t6_nack_clr", 32'(nack_cnt), 32'h0);
        rst       = 1'b0;
        remain[1] = 5;
        remain[3] = 5;
        drive();
        tick();
        chk("t6_rr_ptr0", 32'(owner), 32'h1);
        chk("t6_busy2", 32'(busy), 32'h1);
        remain[1] = 0;
        remain[3] = 0;
        drive();
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
